// File: rtl/fifo_send.sv
`default_nettype none
// ============================================================================
// Module      : fifo_send
// Description : Write-side burst traffic source for the async FIFO
//               (incrementing or 8-bit LFSR pattern).
// Revision    : 1.0
// ============================================================================
module fifo_send #(
    parameter int DW    = 8,
    parameter int LEN_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_w,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [DW-1:0]    seed,
    input  logic [LEN_W-1:0] length,
    input  logic             overflow,
    output logic [DW-1:0]    data_w,
    output logic             wr_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] wr_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] c_LEN_ONE = LEN_W'(1);

    state_t             r_state;
    logic               r_mode;
    logic [LEN_W-1:0]   r_remaining;
    logic [7:0]         r_pat;
    logic [CNT_W-1:0]   r_wr_count;

    logic [7:0]         w_seed8;
    logic [7:0]         w_first;
    logic [7:0]         w_next_pat;
    logic               w_wr_en;

    // Pattern is always 8 bits; the data port is a zero-extended view of it.
    generate
        if (DW >= 8) begin : g_wide
            assign w_seed8 = seed[7:0];
            assign data_w  = DW'(r_pat);
        end else begin : g_narrow
            assign w_seed8 = 8'(seed);
            assign data_w  = r_pat[DW-1:0];
        end
    endgenerate

    // An all-zero LFSR state would lock up, so a zero seed starts at 1.
    assign w_first    = (mode && (w_seed8 == 8'h00)) ? 8'h01 : w_seed8;
    assign w_next_pat = r_mode ? {r_pat[6:0], r_pat[7] ^ r_pat[5] ^ r_pat[4] ^ r_pat[3]}
                               : r_pat + 8'd1;

    assign w_wr_en  = (r_state == S_SEND) && !overflow;
    assign wr_en    = w_wr_en;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign wr_count = r_wr_count;

    always_ff @(posedge clk_w) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mode      <= 1'b0;
            r_remaining <= '0;
            r_pat       <= 8'h00;
            r_wr_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode      <= mode;
                        r_remaining <= length;
                        r_pat       <= w_first;
                        r_state     <= (length == '0) ? S_DONE : S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_wr_en) begin
                        r_pat       <= w_next_pat;
                        r_remaining <= r_remaining - c_LEN_ONE;
                        r_wr_count  <= r_wr_count + CNT_W'(1);
                    end
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (w_wr_en && (r_remaining == c_LEN_ONE)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/fifo_send.md
# fifo_send

Write-side traffic source for the asynchronous FIFO, running in the write clock domain. On a start pulse it writes one burst of `length` words into the FIFO write port. Words are either an incrementing pattern or an 8-bit LFSR pattern. It stalls while the FIFO reports `overflow` (full) and pulses `done` when the burst completes. It is the producer counterpart of the read-side consumer and is used for FIFO bring-up and stress tests.

## Interface
- `DW`, 8: data width. Patterns are defined for 8; wider widths zero-extend the pattern.
- `LEN_W`, 8: width of the burst length field.
- `CNT_W`, 16: width of the lifetime write counter.

- `clk_w`  in  1  write-domain clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- `abort`  in  1  terminates a burst in progress; no `done` pulse.
- `mode`  in  1  0 = incrementing, 1 = LFSR; latched at start.
- `seed`  in  DW  first word of the burst; latched at start.
- `length`  in  LEN_W  number of words in the burst; latched at start.
- `overflow`  in  1  FIFO full flag (write domain); a write is illegal while high.
- `data_w`  out  DW  write data to the FIFO.
- `wr_en`  out  1  write strobe; a word is written on each rising edge where it is high.
- `busy`  out  1  high in SEND and DONE.
- `done`  out  1  one-cycle pulse after the last word is written.
- `wr_count`  out  CNT_W  total words written since reset; wraps modulo 2^CNT_W.

## Operation
- States:
  - IDLE: `busy`=0, `wr_en`=0.
  - SEND: `busy`=1.
  - DONE: `busy`=1, `done`=1 for exactly one cycle.
- IDLE → SEND on `start`=1. The same edge latches `mode` and `length` into `remaining`, and loads `data_w` with `seed`.
  - In LFSR mode, a seed of 0 is replaced by 1.
- IDLE → DONE on `start`=1 when `length`=0. No write occurs; `done` still pulses.
- In SEND, `wr_en` = !`overflow`. This is combinational from state and `overflow`, so no write is ever issued while full.
- On each write edge (SEND and `wr_en`=1):
  - `data_w` advances to the next pattern word.
  - `remaining` decrements by 1.
  - `wr_count` increments by 1.
- SEND → DONE on the write edge where `remaining`=1.
- DONE → IDLE unconditionally after one cycle.
- Incrementing mode: next = `data_w`+1, modulo 2^8 (FF wraps to 00).
- LFSR mode (taps 8,6,5,4): next = {q[6:0], q[7]^q[5]^q[4]^q[3]}.
- `abort` in SEND → IDLE on the next edge.
  - A write coinciding with `abort` still counts.
  - No `done` pulse is generated.
  - `abort` has priority over the SEND → DONE transition.
- `start` outside IDLE is ignored and is not queued.
- `abort` outside SEND is ignored.
- `data_w` holds its last value in IDLE and DONE.
- Reset mid-burst:
  - Returns to IDLE on that edge.
  - All outputs take their reset values.
  - The burst is discarded.

## Timing
- Reset values: `data_w`=0, `wr_en`=0, `busy`=0, `done`=0, `wr_count`=0, state IDLE.
- `start` is sampled at edge E0. SEND begins in cycle 1, and the first `wr_en` can be high in that cycle.
- With no stalls, a burst of N words occupies cycles 1..N, `done` is high in cycle N+1, and the block is back in IDLE at cycle N+2.
  - A new `start` is accepted in cycle N+2.
- Each cycle of `overflow` high in SEND adds exactly one cycle of latency. The sequence of written words is unchanged.
- `overflow` changing mid-cycle affects `wr_en` in the same cycle, because the path is combinational.

## Test plan
- Basic incrementing burst: mode 0, seed FE, length 4, `overflow`=0.
  - Required: writes FE, FF, 00, 01 in cycles 1–4.
  - `done` in cycle 5, `busy` low in cycle 6, `wr_count`=4.
- Full-flag stall: mode 0, seed 10, length 3, `overflow` high in cycles 2–3.
  - Required: 10 written in cycle 1; `wr_en` low in cycles 2–3 with `data_w` holding 11.
  - 11 written in cycle 4, 12 in cycle 5, `done` in cycle 6.
- LFSR burst: mode 1, seed 00, length 5.
  - Required: writes 01, 02, 04, 08, 11.
  - `done` follows; `data_w` holds 23 afterward.
- Zero length and ignored start: start with length 0.
  - Required: no `wr_en`, `done` in cycle 1, `wr_count` unchanged.
- Start while busy: a `start` pulse during a burst.
  - Required: ignored; the burst finishes normally and no second burst follows.
- Abort and reset: `abort` in cycle 3 of a length-8 burst.
  - Required: 3 words written (cycles 1–3), IDLE in cycle 4, no `done`.
- Reset mid-burst: `reset` during a burst.
  - Required: next cycle has all outputs at reset values, with `wr_count`=0.
